// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encoding, FSM states and iteration count for the HI/LO multiply/divide unit.
package muldiv_pkg;
    typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    localparam int ITERS = 32;
    function automatic logic [31:0] mag(input logic [31:0] v, input logic neg);
        return neg ? -v : v;
    endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers and MTHI/MTLO writes.
// One 64-bit shift register is shared by shift-add multiply and restoring divide.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    state_t      state;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        is_div, neg_p, neg_r, dz;
    logic        sa, sb;
    logic [31:0] ma, mb;
    logic [32:0] sum, diff;
    logic [63:0] mul_next, div_next, prod, res;
    // Signed ops (MULT, DIV) have op[0] clear
    assign sa = a[31] & ~op[0];
    assign sb = b[31] & ~op[0];
    assign ma = mag(a, sa);
    assign mb = mag(b, sb);
    always_comb begin
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next = {sum, acc[31:1]};
        diff     = acc[63:31] - {1'b0, opnd};
        div_next = diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
        prod     = neg_p ? -acc : acc;
        res      = is_div ? {mag(acc[63:32], neg_r), dz ? 32'hFFFF_FFFF : mag(acc[31:0], neg_p)} : prod;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        state  <= S_RUN;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op[1];
                        neg_p  <= sa ^ sb;
                        neg_r  <= sa;
                        dz     <= op[1] && b == 32'd0;
                        // Divide iterates on the dividend, multiply on the multiplier
                        acc    <= {32'd0, op[1] ? ma : mb};
                        opnd   <= op[1] ? mb : ma;
                    end
                end
                S_RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(ITERS - 1)) state <= S_DONE;
                end
                S_DONE: begin
                    {hi, lo} <= res;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [63:0] res;
        int          n;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] prev;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    function automatic logic [63:0] model(logic [1:0] o, logic [31:0] x, logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint q, r;
        logic [63:0] p;
        case (o)
            2'b00: p = sx * sy;
            2'b01: p = {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
        endcase
        return p;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no operation outstanding at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                check("hilo", {hi, lo}, e.res);
                check("latency", 64'(cyc - e.n), 64'd33);
                check("busy_at_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    // Called at a negedge; drives start for one edge and records the acceptance edge
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t t;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        t.res = model(o, x, y);
        t.n = cyc;
        exp_q.push_back(t);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {busy, done, hi, lo}, 66'd0);
        reset = 1'b0;
        @(negedge clk);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        check("multu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_idle();
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        issue(2'b11, 32'd100, 32'd0);
        wait_idle();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        issue(2'b10, 32'hFFFF_FFF9, 32'd0);
        wait_idle();
        // MTLO in idle
        prev = hi;
        lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        check("mtlo", {hi, lo}, {prev, 32'hCAFE_F00D});
        check("mtlo_done", {63'd0, done}, 64'd0);
        // Writes and start while busy are ignored
        @(negedge clk);
        issue(2'b01, 32'h0000_1234, 32'h0000_5678);
        repeat (5) @(negedge clk);
        prev = hi;
        start = 1'b1; op = 2'b10; a = 32'd99; b = 32'd7; hi_we = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        start = 1'b0; hi_we = 1'b0;
        check("busy_hold", {31'd0, busy, hi}, {31'd0, 1'b1, prev});
        wait_idle();
        repeat (40) @(negedge clk);
        // MTHI together with start in idle: write lands, completion overwrites
        hi_we = 1'b1; wdata = 32'h1234_5678;
        issue(2'b00, 32'h7FFF_FFFF, 32'h8000_0000);
        hi_we = 1'b0;
        check("mthi_with_start", {32'd0, hi}, 64'h1234_5678);
        wait_idle();
        // Reset mid-divide, then start in the first cycle after release
        @(negedge clk);
        issue(2'b10, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_reset", {busy, done, hi, lo}, 66'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        issue(2'b11, 32'd1000, 32'd7);
        wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            issue(2'($urandom_range(0, 3)), pick(), pick());
            wait_idle();
        end
        repeat (40) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
